// File: rtl/arb2wb_master.sv
// -----------------------------------------------------------------------------
// arb2wb_master
//
// Bridges an arbiter-style request port (req_valid / req_ack handshake) onto a
// Wishbone classic master bus. One transaction is outstanding at a time. All
// outputs come from flops, so there is no combinational path from any input to
// any output.
//
// Optional feature macro: ARB2WB_TIMEOUT_EN
//   defined   - an 8-bit wait counter aborts a bus cycle after TIMEOUT cycles
//               without wbm_ack_i. The aborted request completes with
//               rsp_rdata = 32'hDEAD_BEEF, and the sticky timeout_err flag is set.
//   undefined - BUS waits indefinitely. timeout_err is always 0 and err_clr has
//               no effect.
//
// Parameters:
//   BASE_ADDR  OR'd onto the zero-extended word address to form wbm_adr_o.
//   TIMEOUT    maximum number of BUS cycles to wait for an ack (2..255).
//
// Ports:
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   req_valid/addr/rw/wdata       request from initiator (held until req_ack)
//   req_ack, rsp_rdata            one-cycle completion pulse and read data
//   wbm_cyc_o/stb_o/we_o/sel_o    Wishbone master control
//   wbm_adr_o, wbm_dat_o          Wishbone address and write data
//   wbm_ack_i, wbm_dat_i          Wishbone slave acknowledge and read data
//   busy                          high whenever the bridge is not idle
//   timeout_err, err_clr          sticky timeout flag and its clear
// -----------------------------------------------------------------------------
module arb2wb_master #(
    parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid,
    input  logic [22:0] req_addr,
    input  logic        req_rw,
    input  logic [31:0] req_wdata,
    output logic        req_ack,
    output logic [31:0] rsp_rdata,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy,
    output logic        timeout_err,
    input  logic        err_clr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Address bits [1:0] are forced to zero: the bus is word-addressed.
    localparam logic [22:0] WORD_MASK = 23'h7F_FFFC;

`ifdef ARB2WB_TIMEOUT_EN
    localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [31:0] TO_RDATA  = 32'hDEAD_BEEF;
`endif

    state_t      state_q, state_d;
    logic        cyc_q,   cyc_d;
    logic        we_q,    we_d;
    logic [3:0]  sel_q,   sel_d;
    logic [31:0] adr_q,   adr_d;
    logic [31:0] dat_q,   dat_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q,   ack_d;
    logic        busy_q,  busy_d;
    logic        terr_q,  terr_d;
    logic        terr_set_s;
`ifdef ARB2WB_TIMEOUT_EN
    logic [7:0]  cnt_q,   cnt_d;
`endif

    // Next-state and next-output logic for the request/bus/response sequence.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rdata_d    = rdata_q;
        ack_d      = 1'b0;
        terr_set_s = 1'b0;
`ifdef ARB2WB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_BUS;
                    cyc_d   = 1'b1;
                    sel_d   = 4'hF;
                    we_d    = req_rw;
                    adr_d   = BASE_ADDR | {9'b0, req_addr & WORD_MASK};
                    dat_d   = req_wdata;
`ifdef ARB2WB_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BUS: begin
                // An ack always wins, even in the cycle the wait budget expires.
                if (wbm_ack_i) begin
                    if (!we_q) begin
                        rdata_d = wbm_dat_i;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    cyc_d   = 1'b0;
                    sel_d   = 4'h0;
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                end
`ifdef ARB2WB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    rdata_d    = TO_RDATA;
                    cyc_d      = 1'b0;
                    sel_d      = 4'h0;
                    ack_d      = 1'b1;
                    terr_set_s = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = ST_BUS;
                end
`else
                else begin
                    state_d = ST_BUS;
                end
`endif
            end

            ST_RESP: begin
                // The ack pulse is already on the output this cycle.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                sel_d   = 4'h0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);

        // Set has priority over clear when both happen in one cycle.
        if (terr_set_s) begin
            terr_d = 1'b1;
        end else if (err_clr) begin
            terr_d = 1'b0;
        end else begin
            terr_d = terr_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            adr_q   <= 32'h0000_0000;
            dat_q   <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
`ifdef ARB2WB_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
`ifdef ARB2WB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign req_ack     = ack_q;
    assign rsp_rdata   = rdata_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign busy        = busy_q;
    // Without the timeout feature terr_q can never leave its reset value of 0.
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_arb2wb_master.sv
`timescale 1ns/1ps
module tb_arb2wb_master;

    localparam int          TMO  = 8;
    localparam logic [31:0] BASE = 32'h3800_0000;
`ifdef ARB2WB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        wb_rst_i;
    logic        req_valid;
    logic [22:0] req_addr;
    logic        req_rw;
    logic [31:0] req_wdata;
    logic        req_ack;
    logic [31:0] rsp_rdata;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        busy;
    logic        timeout_err;
    logic        err_clr;

    arb2wb_master #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (wb_rst_i),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_rw      (req_rw),
        .req_wdata   (req_wdata),
        .req_ack     (req_ack),
        .rsp_rdata   (rsp_rdata),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_dat_i   (wbm_dat_i),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        terr;
    } rsp_t;

    bus_t        bus_q[$];
    rsp_t        rsp_q[$];
    int          rise_q[$];

    int          errors = 0;
    int          checks = 0;
    int          cyc_cnt = 0;
    bit          in_reset = 1'b1;
    bit          stray = 1'b0;
    int          slv_waits = 0;
    logic [31:0] slv_data = 32'h0;
    logic [31:0] model_rdata = 32'h0;
    logic        model_terr = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Wishbone slave model: acks after slv_waits wait states, random data otherwise.
    initial begin
        int scnt;
        scnt = 0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            if (stray) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = $urandom;
            end else if (wbm_cyc_o && wbm_stb_o) begin
                if (scnt == slv_waits) begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = slv_data;
                end else begin
                    wbm_ack_i = 1'b0;
                    wbm_dat_i = $urandom;
                end
                scnt++;
            end else begin
                wbm_ack_i = 1'b0;
                wbm_dat_i = $urandom;
                scnt = 0;
            end
        end
    end

    // Monitor: checks bus outputs while cyc is high and pops responses on req_ack.
    initial begin
        bit   prev_cyc;
        rsp_t e;
        prev_cyc = 1'b0;
        forever begin
            @(negedge clk);
            if (!in_reset) begin
                if (wbm_cyc_o) begin
                    if (!prev_cyc) rise_q.push_back(cyc_cnt);
                    if (bus_q.size() == 0) begin
                        chk("unexpected_cyc", 64'(wbm_cyc_o), 64'd0);
                    end else begin
                        chk("bus_adr", 64'(wbm_adr_o), 64'(bus_q[0].adr));
                        chk("bus_we", 64'(wbm_we_o), 64'(bus_q[0].we));
                        chk("bus_sel_stb", 64'({wbm_sel_o, wbm_stb_o}), 64'({4'hF, 1'b1}));
                        if (bus_q[0].we) chk("bus_dat", 64'(wbm_dat_o), 64'(bus_q[0].dat));
                    end
                end else if (prev_cyc && bus_q.size() > 0) begin
                    void'(bus_q.pop_front());
                end
                if (req_ack) begin
                    if (rsp_q.size() == 0) begin
                        chk("spurious_ack", 64'(req_ack), 64'd0);
                    end else begin
                        e = rsp_q.pop_front();
                        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                        chk("rsp_terr", 64'(timeout_err), 64'(e.terr));
                    end
                end
            end
            prev_cyc = wbm_cyc_o;
        end
    end

    // One request: compute expectations from the protocol rules, then drive it.
    task automatic txn(input logic [22:0] a, input logic rw, input logic [31:0] wd,
                       input int w, input logic [31:0] sd);
        bus_t b;
        rsp_t r;
        bit   to;
        int   lat;
        int   k;
        @(negedge clk);
        #1;
        to  = TO_EN && (w >= TMO);
        lat = to ? TMO + 1 : w + 2;
        b.adr = BASE | ({9'd0, a} & 32'hFFFF_FFFC);
        b.we  = rw;
        b.dat = wd;
        if (to) begin
            model_rdata = 32'hDEAD_BEEF;
            model_terr  = 1'b1;
        end else if (!rw) begin
            model_rdata = sd;
        end
        r.rdata = model_rdata;
        r.terr  = model_terr;
        bus_q.push_back(b);
        rsp_q.push_back(r);
        slv_waits = w;
        slv_data  = sd;
        req_valid = 1'b1;
        req_addr  = a;
        req_rw    = rw;
        req_wdata = wd;
        @(posedge clk);
        k = 0;
        while (k < 400) begin
            @(negedge clk);
            k++;
            if (k == 1) chk("cyc_after_accept", 64'({wbm_cyc_o, wbm_stb_o, busy}), 64'(3'b111));
            if (req_ack) break;
        end
        req_valid = 1'b0;
        chk("ack_latency", 64'(k), 64'(lat));
    endtask

    initial begin
        bus_t b;
        wb_rst_i  = 1'b1;
        req_valid = 1'b0;
        req_addr  = 23'h0;
        req_rw    = 1'b0;
        req_wdata = 32'h0;
        err_clr   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ctl", 64'({req_ack, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, busy, timeout_err}), 64'd0);
        chk("rst_adr", 64'(wbm_adr_o), 64'd0);
        chk("rst_dat", 64'(wbm_dat_o), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        wb_rst_i = 1'b0;
        in_reset = 1'b0;

        // Zero-wait read, then 3-wait write
        txn(23'h000104, 1'b0, 32'h0, 0, 32'h1234_5678);
        txn(23'h000010, 1'b1, 32'hCAFE_0001, 3, 32'h5555_AAAA);

        // Back-to-back zero-wait reads
        txn(23'h000200, 1'b0, 32'h0, 0, 32'h0BAD_F00D);
        txn(23'h000207, 1'b0, 32'h0, 0, 32'h7777_0001);
        chk("b2b_spacing", 64'(rise_q[$] - rise_q[$-1]), 64'd3);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            txn(ra[22:0], 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 5), $urandom);
        end

        // Reset while a bus cycle is in progress
        @(negedge clk);
        #1;
        b.adr = BASE | 32'h0000_0040;
        b.we  = 1'b0;
        b.dat = 32'h0;
        bus_q.push_back(b);
        slv_waits = 1000;
        req_valid = 1'b1;
        req_addr  = 23'h000041;
        req_rw    = 1'b0;
        @(posedge clk);
        repeat (3) @(negedge clk);
        #1;
        in_reset  = 1'b1;
        wb_rst_i  = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("midrst_ctl", 64'({req_ack, wbm_cyc_o, wbm_stb_o, busy}), 64'd0);
        chk("midrst_rdata", 64'(rsp_rdata), 64'd0);
        bus_q.delete();
        rsp_q.delete();
        model_rdata = 32'h0;
        model_terr  = 1'b0;
        slv_waits   = 0;
        wb_rst_i    = 1'b0;
        in_reset    = 1'b0;
        stray       = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("stray_ack_ignored", 64'({req_ack, wbm_cyc_o, busy}), 64'd0);
        end
        stray = 1'b0;

        // Timeout with a slave that never acks
        if (TO_EN) txn(23'h000300, 1'b0, 32'h0, 1000, 32'h0);
        @(negedge clk);
        #1;
        chk("terr_sticky", 64'(timeout_err), 64'(model_terr));
        err_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        err_clr    = 1'b0;
        model_terr = 1'b0;
        chk("err_clr", 64'(timeout_err), 64'(model_terr));

        // Ack arriving in the last allowed BUS cycle
        txn(23'h000304, 1'b0, 32'h0, TMO - 1, 32'h0000_00AA);
        txn(23'h000308, 1'b1, 32'h1111_2222, 1, 32'h0);

        repeat (5) @(negedge clk);
        chk("rsp_drained", 64'(rsp_q.size()), 64'd0);
        chk("bus_drained", 64'(bus_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
